// File: rtl/multi_clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_clock_divider                                          |
// | Description : Multi-channel runtime-programmable clock/tick generator.     |
// |               Each channel divides clk by a written divisor and emits      |
// |               either a 50% square wave (toggle) or a one-cycle strobe      |
// |               (pulse), plus a terminal-count tick in both modes.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multi_clock_divider #(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = 30,
  parameter int  DEFAULT_DIV = 1,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] sclk,
  output logic [NUM_CH-1:0] tick,
  output logic              div_err
);

  localparam logic [CNT_W-1:0] c_DEFAULT = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [CH_W:0]    c_NUM_CH  = (CH_W + 1)'(NUM_CH);

  logic w_wr_ok;
  logic r_div_err;

  // A write is honoured only for a non-zero divisor aimed at an existing channel.
  assign w_wr_ok = div_wr && (div_val != '0) && ({1'b0, div_ch} < c_NUM_CH);
  assign div_err = r_div_err;

  // Flag every rejected write for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_err <= 1'b0;
    end else begin
      r_div_err <= div_wr && !w_wr_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_shd;
    logic             r_sclk;
    logic             r_tick;
    logic             w_hit;
    logic             w_term;
    logic [CNT_W-1:0] w_next_div;

    assign w_hit      = w_wr_ok && (div_ch == CH_W'(i));
    // A write landing on a reload point goes straight into the active divisor.
    assign w_next_div = w_hit ? div_val : r_div_shd;
    assign w_term     = (r_count == (r_div_act - c_ONE));

    assign sclk[i] = r_sclk;
    assign tick[i] = r_tick;

    // Shadow divisor: holds the most recent accepted write for this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div_shd <= c_DEFAULT;
      end else if (w_hit) begin
        r_div_shd <= div_val;
      end
    end

    // Counter, outputs and active divisor; the divisor only reloads at period end.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count   <= '0;
        r_div_act <= c_DEFAULT;
        r_sclk    <= 1'b0;
        r_tick    <= 1'b0;
      end else if (!en[i]) begin
        r_count   <= '0;
        r_div_act <= w_next_div;
        r_sclk    <= 1'b0;
        r_tick    <= 1'b0;
      end else if (w_term) begin
        r_count   <= '0;
        r_div_act <= w_next_div;
        r_tick    <= 1'b1;
        r_sclk    <= mode[i] ? 1'b1 : ~r_sclk;
      end else begin
        r_count <= r_count + c_ONE;
        r_tick  <= 1'b0;
        if (mode[i]) begin
          r_sclk <= 1'b0;
        end
      end
    end
  end : g_ch

endmodule
`default_nettype wire
